// File: rtl/push_fifo.sv
// push_fifo: push-handshake FIFO between the RS232 receiver and a push-stream consumer.
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset
//   i_idata     input word, taken when i_ienable=1
//   i_ienable   input push strobe
//   o_iafull    registered almost-full flag (drives RTSn backpressure upstream)
//   o_odata     output word, valid while o_oenable=1
//   o_oenable   output push strobe
//   i_oafull    downstream almost-full, 1 stops emission
//   o_overflow  sticky flag: a push was dropped because the FIFO was full
module push_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_idata,
    input  logic             i_ienable,
    output logic             o_iafull,
    output logic [WIDTH-1:0] o_odata,
    output logic             o_oenable,
    input  logic             i_oafull,
    output logic             o_overflow
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(2 ** DEPTH_LOG2);
    localparam logic [CW-1:0] C_MARGIN = CW'(AFULL_MARGIN);
    logic [WIDTH-1:0]      r_mem [2 ** DEPTH_LOG2];
    logic [CW-1:0]         r_count;
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic                  r_iafull, r_oenable, r_overflow;
    logic [WIDTH-1:0]      r_odata;
    logic                  w_pop, w_accept;
    logic [CW-1:0]         w_count_next;
    // A full FIFO still accepts when a pop frees a slot on the same edge.
    assign w_pop        = (r_count != '0) && !i_oafull;
    assign w_accept     = i_ienable && (r_count != C_DEPTH || w_pop);
    assign w_count_next = r_count + CW'(w_accept) - CW'(w_pop);
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_accept)
            r_mem[r_wptr] <= i_idata;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_iafull   <= 1'b0;
            r_oenable  <= 1'b0;
            r_odata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_iafull  <= (C_DEPTH - w_count_next) <= C_MARGIN;
            r_oenable <= w_pop;
            if (w_pop) begin
                r_odata <= r_mem[r_rptr];
                r_rptr  <= r_rptr + 1'b1;
            end
            if (w_accept)
                r_wptr <= r_wptr + 1'b1;
            if (i_ienable && !w_accept)
                r_overflow <= 1'b1;
        end
    end
    assign o_iafull   = r_iafull;
    assign o_odata    = r_odata;
    assign o_oenable  = r_oenable;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_push_fifo.sv
// tb_push_fifo: scoreboard bench for push_fifo with DEPTH=4, AFULL_MARGIN=1.
module tb_push_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] idata = '0;
    logic       ienable = 1'b0;
    logic       oafull = 1'b0;
    logic       iafull, oenable, overflow;
    logic [7:0] odata;
    logic       last_oafull = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];

    push_fifo #(.WIDTH(8), .DEPTH_LOG2(2), .AFULL_MARGIN(1)) dut (
        .i_clock(clk), .i_reset(rst), .i_idata(idata), .i_ienable(ienable),
        .o_iafull(iafull), .o_odata(odata), .o_oenable(oenable),
        .i_oafull(oafull), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one push for a single edge; expected words enter the scoreboard.
    task automatic push(input logic [7:0] d, input bit accepted);
        ienable = 1'b1;
        idata   = d;
        if (accepted) q.push_back(d);
        tick();
        ienable = 1'b0;
    endtask

    always @(posedge clk) last_oafull <= oafull;

    always @(negedge clk) begin
        if (oenable) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got word %0h expected no output at %0t", odata, $time);
            end else
                check("stream_data", {24'd0, odata}, {24'd0, q.pop_front()});
        end
        if (last_oafull)
            check("oafull_gate", {31'd0, oenable}, 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset state and single-word latency
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_oenable", {31'd0, oenable}, 0);
        check("rst_odata", {24'd0, odata}, 0);
        check("rst_iafull", {31'd0, iafull}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_count", {29'd0, dut.r_count}, 0);
        push(8'hA5, 1);
        check("t1_no_fallthrough", {31'd0, oenable}, 0);
        tick();
        check("t1_oenable", {31'd0, oenable}, 1);
        check("t1_odata", {24'd0, odata}, 32'hA5);
        tick();
        check("t1_oenable_off", {31'd0, oenable}, 0);
        check("t1_iafull", {31'd0, iafull}, 0);
        check("t1_count", {29'd0, dut.r_count}, 0);

        // 2: almost-full rise and fall
        oafull = 1'b1;
        push(8'h01, 1);
        push(8'h02, 1);
        check("t2_iafull_2", {31'd0, iafull}, 0);
        push(8'h03, 1);
        check("t2_iafull_3", {31'd0, iafull}, 1);
        push(8'h04, 1);
        check("t2_count_full", {29'd0, dut.r_count}, 4);
        check("t2_iafull_4", {31'd0, iafull}, 1);
        oafull = 1'b0;
        tick();
        check("t2_pop1_oen", {31'd0, oenable}, 1);
        check("t2_pop1_iafull", {31'd0, iafull}, 1);
        tick();
        check("t2_pop2_oen", {31'd0, oenable}, 1);
        check("t2_pop2_iafull", {31'd0, iafull}, 0);
        tick();
        check("t2_pop3_oen", {31'd0, oenable}, 1);
        tick();
        check("t2_pop4_oen", {31'd0, oenable}, 1);
        tick();
        check("t2_idle", {31'd0, oenable}, 0);

        // 3: overflow on full FIFO with consumer stalled
        oafull = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 1);
        push(8'h55, 0);
        check("t3_overflow", {31'd0, overflow}, 1);
        check("t3_count", {29'd0, dut.r_count}, 4);
        oafull = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check("t3_drained", {29'd0, dut.r_count}, 0);
        check("t3_overflow_sticky", {31'd0, overflow}, 1);
        check("t3_idle", {31'd0, oenable}, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_overflow_clr", {31'd0, overflow}, 0);

        // 4: full FIFO with push and pop every cycle, pointers wrap
        oafull = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 1);
        check("t4_wptr_wrap0", {30'd0, dut.r_wptr}, 0);
        oafull = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(8'h34 + 8'(i), 1);
            check("t4_count", {29'd0, dut.r_count}, 4);
            check("t4_stream", {31'd0, oenable}, 1);
            check("t4_overflow", {31'd0, overflow}, 0);
            if (i == 3 || i == 7) begin
                check("t4_wptr_wrap", {30'd0, dut.r_wptr}, 0);
                check("t4_rptr_wrap", {30'd0, dut.r_rptr}, 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_drain_stream", {31'd0, oenable}, 1);
        end
        tick();
        check("t4_idle", {31'd0, oenable}, 0);

        // 5: oafull toggling every cycle, one push per two cycles
        for (int i = 0; i < 16; i++) begin
            oafull  = ~oafull;
            ienable = 1'b1;
            idata   = 8'h10 + 8'(i);
            q.push_back(idata);
            tick();
            ienable = 1'b0;
            oafull  = ~oafull;
            tick();
        end
        oafull = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check("t5_drained", q.size(), 0);
        check("t5_overflow", {31'd0, overflow}, 0);

        // 6: reset mid-stream discards contents and same-cycle push/pop
        oafull = 1'b1;
        for (int i = 0; i < 3; i++) push(8'h61 + 8'(i), 1);
        check("t6_count3", {29'd0, dut.r_count}, 3);
        check("t6_iafull3", {31'd0, iafull}, 1);
        rst     = 1'b1;
        oafull  = 1'b0;
        ienable = 1'b1;
        idata   = 8'h64;
        tick();
        q.delete();
        rst     = 1'b0;
        ienable = 1'b0;
        check("t6_count", {29'd0, dut.r_count}, 0);
        check("t6_oenable", {31'd0, oenable}, 0);
        check("t6_iafull", {31'd0, iafull}, 0);
        check("t6_overflow", {31'd0, overflow}, 0);
        tick();
        check("t6_no_stale", {31'd0, oenable}, 0);
        push(8'h7E, 1);
        tick();
        check("t6_fresh_oen", {31'd0, oenable}, 1);
        check("t6_fresh_data", {24'd0, odata}, 32'h7E);
        tick();
        tick();
        check("final_scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
